// File: rtl/me_search_ctrl.sv
// -----------------------------------------------------------------------------
// me_search_ctrl
//
// Sequences one full-search motion-estimation pass: one 8x8 current block is
// matched against a 23x23 reference window. Reference columns are pulled from
// the column source one per accepted handshake and pushed into the reference
// FIFO. Each accepted column produces one 16-candidate vertical batch in the
// free-running AD_ARRAY -> ADD_8 -> MIN_16 datapath. A tag pipe tracks which
// batch results are real. The controller keeps the running minimum SAD and
// its motion vector.
//
// Ports
//   clk_i, rst_n_i  clock and asynchronous active-low reset
//   start_i         start pulse, sampled in IDLE only
//   busy_o          high from LOAD until the cycle before DONE
//   cur_load_o      one-cycle pulse; current-block register captures the block
//   col_valid_i     column source presents a column
//   col_ready_o     controller accepts a column this cycle
//   fifo_shift_o    column handshake; the FIFO shifts the column in
//   col_idx_o       index of the column requested next (0..NUM_COLS-1)
//   batch_msad_i    MIN_16 minimum SAD of the batch now on the bus
//   batch_idx_i     MIN_16 vertical offset of that minimum
//   best_sad_o      running / final minimum SAD
//   best_mv_x_o     horizontal offset of the best match
//   best_mv_y_o     vertical offset of the best match
//   done_o          one-cycle pulse; best_* are final
// -----------------------------------------------------------------------------
module me_search_ctrl #(
   parameter int EDGE_LEN      = 8,
   parameter int H_CAND        = 16,
   parameter int SAD_BIT_WIDTH = 14,
   parameter int PIPE_LAT      = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     start_i,
   output logic                     busy_o,
   output logic                     cur_load_o,
   input  logic                     col_valid_i,
   output logic                     col_ready_o,
   output logic                     fifo_shift_o,
   output logic [4:0]               col_idx_o,
   input  logic [SAD_BIT_WIDTH-1:0] batch_msad_i,
   input  logic [3:0]               batch_idx_i,
   output logic [SAD_BIT_WIDTH-1:0] best_sad_o,
   output logic [3:0]               best_mv_x_o,
   output logic [3:0]               best_mv_y_o,
   output logic                     done_o
);

   localparam int NUM_COLS = EDGE_LEN + H_CAND - 1;
   localparam logic [4:0] LAST_COL    = 5'(NUM_COLS - 1);
   localparam logic [4:0] FIRST_VALID = 5'(EDGE_LEN - 1);
   // Every tag stage except the output one; when these are all empty, the
   // entry at the output is consumed this cycle and the pipe is drained.
   localparam logic [PIPE_LAT-1:0] UPSTREAM_MASK = {PIPE_LAT{1'b1}} >> 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_STREAM,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                   state_q, state_d;
   logic [4:0]               col_idx_q;
   logic [PIPE_LAT-1:0]      tag_vld_q;
   logic [3:0]               tag_x_q [PIPE_LAT];
   logic [SAD_BIT_WIDTH-1:0] best_sad_q;
   logic [3:0]               best_x_q, best_y_q;

   logic       start_acc;
   logic       last_shift;
   logic       push_vld;
   logic [3:0] push_x;
   logic       capture;

   assign start_acc    = (state_q == S_IDLE) && start_i;
   assign fifo_shift_o = col_valid_i && col_ready_o;
   assign last_shift   = fifo_shift_o && (col_idx_q == LAST_COL);

   // Columns 0..EDGE_LEN-2 only prime the FIFO; their batches are not
   // complete candidates, so they enter the tag pipe as invalid.
   assign push_vld = fifo_shift_o && (col_idx_q >= FIRST_VALID);
   assign push_x   = 4'(col_idx_q - FIRST_VALID);

   // Strict less-than keeps the earliest candidate on ties.
   assign capture = tag_vld_q[PIPE_LAT-1] && (batch_msad_i < best_sad_q);

   // NOTE: every output of this block gets a default before the case, so no
   // path through it leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      busy_o      = 1'b0;
      cur_load_o  = 1'b0;
      col_ready_o = 1'b0;
      done_o      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start_i) state_d = S_LOAD;
         end
         S_LOAD: begin
            busy_o     = 1'b1;
            cur_load_o = 1'b1;
            state_d    = S_STREAM;
         end
         S_STREAM: begin
            busy_o      = 1'b1;
            col_ready_o = 1'b1;
            if (last_shift) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            busy_o = 1'b1;
            if ((tag_vld_q & UPSTREAM_MASK) == '0) state_d = S_DONE;
         end
         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= S_IDLE;
         col_idx_q  <= '0;
         tag_vld_q  <= '0;
         best_sad_q <= '1;
         best_x_q   <= '0;
         best_y_q   <= '0;
      end else begin
         state_q <= state_d;

         if (start_acc || state_q == S_LOAD) begin
            col_idx_q <= '0;
         end else if (fifo_shift_o && !last_shift) begin
            col_idx_q <= col_idx_q + 5'd1;
         end

         // The tag pipe advances every cycle: the datapath behind the FIFO
         // never stalls, only the column handshake does.
         tag_vld_q[0] <= push_vld;
         for (int i = 1; i < PIPE_LAT; i++) begin
            tag_vld_q[i] <= tag_vld_q[i-1];
         end

         if (start_acc) begin
            best_sad_q <= '1;
            best_x_q   <= '0;
            best_y_q   <= '0;
         end else if (capture) begin
            best_sad_q <= batch_msad_i;
            best_x_q   <= tag_x_q[PIPE_LAT-1];
            best_y_q   <= batch_idx_i;
         end
      end
   end

   // NOTE: the x payload is only ever read when its valid bit is set, and the
   // valid bits are reset, so the payload registers carry no reset.
   always_ff @(posedge clk_i) begin
      tag_x_q[0] <= push_x;
      for (int i = 1; i < PIPE_LAT; i++) begin
         tag_x_q[i] <= tag_x_q[i-1];
      end
   end

   assign col_idx_o   = col_idx_q;
   assign best_sad_o  = best_sad_q;
   assign best_mv_x_o = best_x_q;
   assign best_mv_y_o = best_y_q;

endmodule

// File: tb/tb_me_search_ctrl.sv
// -----------------------------------------------------------------------------
// tb_me_search_ctrl
//
// Directed bench for me_search_ctrl. A small behavioural model of the
// AD/MIN datapath returns, PIPE_LAT cycles after each observed column shift,
// a scenario-specific SAD/index for that column's batch (and a zero-SAD
// garbage value whenever no real batch is due). Expected results are
// hand-computed constants per scenario.
// -----------------------------------------------------------------------------
module tb_me_search_ctrl;

   localparam int          PIPE_LAT = 2;
   localparam logic [13:0] ALL_ONES = 14'h3fff;

   logic        clk_i        = 1'b0;
   logic        rst_n_i      = 1'b0;
   logic        start_i      = 1'b0;
   logic        col_valid_i  = 1'b0;
   logic [13:0] batch_msad_i = '0;
   logic [3:0]  batch_idx_i  = '0;
   logic        busy_o, cur_load_o, col_ready_o, fifo_shift_o, done_o;
   logic [4:0]  col_idx_o;
   logic [13:0] best_sad_o;
   logic [3:0]  best_mv_x_o, best_mv_y_o;

   int n_cmp = 0;
   int n_bad = 0;

   // Hand-computed results: {sad, x, y} per scenario.
   int exp_sad [4] = '{37, 50, 20, 300};
   int exp_x   [4] = '{5, 0, 10, 0};
   int exp_y   [4] = '{9, 3, 4, 0};

   me_search_ctrl #(
      .EDGE_LEN(8), .H_CAND(16), .SAD_BIT_WIDTH(14), .PIPE_LAT(PIPE_LAT)
   ) dut (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .start_i     (start_i),
      .busy_o      (busy_o),
      .cur_load_o  (cur_load_o),
      .col_valid_i (col_valid_i),
      .col_ready_o (col_ready_o),
      .fifo_shift_o(fifo_shift_o),
      .col_idx_o   (col_idx_o),
      .batch_msad_i(batch_msad_i),
      .batch_idx_i (batch_idx_i),
      .best_sad_o  (best_sad_o),
      .best_mv_x_o (best_mv_x_o),
      .best_mv_y_o (best_mv_y_o),
      .done_o      (done_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Datapath model: batch result for horizontal candidate x.
   task automatic model(input int scen, input int x,
                        output logic [13:0] sad, output logic [3:0] idx);
      case (scen)
         0: begin
            sad = (x == 5) ? 14'd37 : 14'(100 + x);
            idx = (x == 5) ? 4'd9 : 4'(15 - x);
         end
         1: begin
            sad = 14'd50;
            idx = 4'd3;
         end
         2: begin
            sad = (x == 10 || x == 12) ? 14'd20 : 14'd90;
            idx = (x == 10) ? 4'd4 : ((x == 12) ? 4'd6 : 4'd1);
         end
         default: begin
            sad = 14'(300 + x);
            idx = 4'(x);
         end
      endcase
   endtask

   task automatic check_reset_outputs(input string nm);
      check({nm, " busy"},     busy_o,       0);
      check({nm, " cur_load"}, cur_load_o,   0);
      check({nm, " ready"},    col_ready_o,  0);
      check({nm, " shift"},    fifo_shift_o, 0);
      check({nm, " done"},     done_o,       0);
      check({nm, " col_idx"},  col_idx_o,    0);
      check({nm, " best_sad"}, best_sad_o,   ALL_ONES);
      check({nm, " mv_x"},     best_mv_x_o,  0);
      check({nm, " mv_y"},     best_mv_y_o,  0);
   endtask

   // One full pass. Entered and left at posedge+1 with the DUT in IDLE.
   task automatic run_pass(input int scen, input bit stall, input bit poke, input string nm);
      bit   hv [0:399];
      int   hk [0:399];
      bit   stall_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      int   shifts = 0, loads = 0, dones = 0;
      int   first_busy = -1, done_at = -1, first_shift = -1, last_shift = -1;
      int   idx_err = 0, ready_err = 0, mask_err = 0, busy_at_done = 0;
      bit   seen_valid = 1'b0;
      bit   drive_valid;
      logic [13:0] s;
      logic [3:0]  y;

      start_i     = 1'b1;
      col_valid_i = 1'b0;
      @(posedge clk_i); #1;
      start_i = 1'b0;

      for (int cyc = 0; cyc < 400; cyc++) begin
         col_valid_i = stall ? stall_pat[cyc % 4] : 1'b1;
         start_i     = poke && (cyc == 10 || cyc == 26);
         drive_valid = (cyc >= PIPE_LAT) && hv[cyc-PIPE_LAT] && (hk[cyc-PIPE_LAT] >= 7);
         if (drive_valid) begin
            model(scen, hk[cyc-PIPE_LAT] - 7, s, y);
            batch_msad_i = s;
            batch_idx_i  = y;
         end else begin
            batch_msad_i = '0;
            batch_idx_i  = 4'hf;
         end
         #4;
         if (busy_o && first_busy < 0) first_busy = cyc;
         if (cur_load_o) loads++;
         if (done_o) begin
            dones++;
            if (done_at < 0) done_at = cyc;
            if (busy_o) busy_at_done++;
         end
         if (col_idx_o !== 5'(shifts < 23 ? shifts : 22)) idx_err++;
         if (col_ready_o !== (cyc >= 1 && shifts < 23)) ready_err++;
         if (fifo_shift_o !== (col_ready_o & col_valid_i)) ready_err++;
         if (!seen_valid && best_sad_o !== ALL_ONES) mask_err++;
         seen_valid |= drive_valid;
         hv[cyc] = fifo_shift_o;
         hk[cyc] = shifts;
         if (fifo_shift_o) begin
            if (first_shift < 0) first_shift = cyc;
            last_shift = cyc;
            shifts++;
         end
         @(posedge clk_i); #1;
         if (done_at >= 0 && cyc >= done_at + 4) break;
      end
      start_i     = 1'b0;
      col_valid_i = 1'b0;

      check({nm, " done seen"},       done_at >= 0, 1);
      check({nm, " shifts"},          shifts, 23);
      check({nm, " cur_load pulses"}, loads, 1);
      check({nm, " done pulses"},     dones, 1);
      check({nm, " first busy"},      first_busy, 0);
      check({nm, " done latency"},    done_at, last_shift + PIPE_LAT + 1);
      if (!stall) begin
         check({nm, " first shift"}, first_shift, 1);
         check({nm, " last shift"},  last_shift, 23);
         check({nm, " pass length"}, done_at, 26);
      end
      check({nm, " col_idx errs"},    idx_err, 0);
      check({nm, " ready errs"},      ready_err, 0);
      check({nm, " fill mask errs"},  mask_err, 0);
      check({nm, " busy at done"},    busy_at_done, 0);
      check({nm, " best_sad"},        best_sad_o, exp_sad[scen]);
      check({nm, " mv_x"},            best_mv_x_o, exp_x[scen]);
      check({nm, " mv_y"},            best_mv_y_o, exp_y[scen]);
   endtask

   // Start a pass, then pull reset low between edges once column 12 is next.
   task automatic reset_mid();
      int n = 0;
      start_i      = 1'b1;
      col_valid_i  = 1'b1;
      batch_msad_i = '0;
      batch_idx_i  = 4'd2;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      while (col_idx_o !== 5'd12 && n < 100) begin
         @(posedge clk_i); #1;
         n++;
      end
      check("abort reached col 12", col_idx_o, 12);
      check("abort best captured", best_sad_o, 0);
      #3;
      rst_n_i = 1'b0;
      #1;
      check_reset_outputs("abort");
      @(posedge clk_i); #1;
      col_valid_i = 1'b0;
      rst_n_i     = 1'b1;
      @(posedge clk_i); #1;
      check("abort stays idle", busy_o, 0);
   endtask

   initial begin
      #12;
      check_reset_outputs("reset");
      @(posedge clk_i); #1;
      rst_n_i = 1'b1;
      @(posedge clk_i); #1;

      run_pass(0, 1'b0, 1'b0, "basic");
      run_pass(0, 1'b1, 1'b0, "stall");
      run_pass(1, 1'b0, 1'b0, "tie_all");
      run_pass(2, 1'b0, 1'b1, "tie_x_poke");
      run_pass(3, 1'b0, 1'b0, "fill_mask");
      reset_mid();
      run_pass(0, 1'b0, 1'b0, "restart");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
